// File: rtl/fetch_queue_if.sv
// Fetch queue bus: imem address/data, redirect request and decode handshake.
// master = fetch_queue side, slave = imem/decode/branch-resolution side.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  logic [5:0]             FetchAddr;
  logic [31:0]            ImemDataA;
  logic [31:0]            ImemDataB;
  logic                   Redirect;
  logic [5:0]             RedirectAddr;
  logic                   InstrValid;
  logic [31:0]            Instr;
  logic [5:0]             InstrPC;
  logic                   InstrReady;
  logic [$clog2(DEPTH):0] Count;

  modport master (
    output FetchAddr, InstrValid, Instr, InstrPC, Count,
    input  ImemDataA, ImemDataB, Redirect, RedirectAddr, InstrReady
  );

  modport slave (
    input  FetchAddr, InstrValid, Instr, InstrPC, Count,
    output ImemDataA, ImemDataB, Redirect, RedirectAddr, InstrReady
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch buffer: enqueues imem word pairs into a circular FIFO and
// hands one instruction per cycle to decode; Redirect flushes and restarts fetch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [5:0]  RESET_PC = 6'd0
) (
  input  logic           CLK,
  input  logic           RST,
  fetch_queue_if.master  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [37:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    fetch_addr_q, fetch_addr_d;

  logic          valid;
  logic          pop;
  logic          wrap;
  logic          can_push;
  logic [1:0]    push_n;
  logic          wr0, wr1;
  logic [PW-1:0] tail_p1;
  logic [37:0]   entry0, entry1;
  logic [37:0]   head_entry;

  always_comb begin
    valid    = (count_q != '0) && !bus.Redirect;
    pop      = valid && bus.InstrReady;
    wrap     = (fetch_addr_q == 6'd63);
    // Push is judged on registered Count so a full queue never takes a lone entry.
    can_push = !bus.Redirect && (count_q <= CW'(DEPTH - 2));
    push_n   = can_push ? (wrap ? 2'd1 : 2'd2) : 2'd0;
    wr0      = can_push;
    wr1      = can_push && !wrap;
    tail_p1  = tail_q + PW'(1);
    entry0   = {bus.ImemDataA, fetch_addr_q};
    entry1   = {bus.ImemDataB, fetch_addr_q + 6'd1};

    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    if (bus.Redirect) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      fetch_addr_d = bus.RedirectAddr;
    end else begin
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + CW'(push_n) - CW'(pop);
      if (can_push) begin
        fetch_addr_d = wrap ? 6'd0 : fetch_addr_q + 6'd2;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_PC;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr0) mem_q[tail_q]  <= entry0;
    if (wr1) mem_q[tail_p1] <= entry1;
  end

  always_comb begin
    head_entry     = mem_q[head_q];
    bus.FetchAddr  = fetch_addr_q;
    bus.Count      = count_q;
    bus.InstrValid = valid;
    bus.Instr      = '0;
    bus.InstrPC    = '0;
    if (count_q != '0) begin
      bus.Instr   = head_entry[37:6];
      bus.InstrPC = head_entry[5:0];
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table for fill/full/wrap/redirect,
// plus async reset and a scoreboarded streaming run.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] B_SENTINEL = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(6'd0)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.master)
  );

  logic [31:0] imem [64];
  assign bus.ImemDataA = imem[bus.FetchAddr];
  assign bus.ImemDataB = (bus.FetchAddr == 6'd63) ? B_SENTINEL : imem[bus.FetchAddr + 6'd1];

  typedef struct {
    logic        redirect;
    logic [5:0]  raddr;
    logic        ready;
    logic        pre_valid;
    int unsigned count;
    logic [5:0]  fetch;
    logic [5:0]  pc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  pc;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic [5:0] ra, input logic rdy, input logic pv,
                     input int unsigned c, input logic [5:0] f, input logic [5:0] p);
    vec_t v;
    v.redirect = rd; v.raddr = ra; v.ready = rdy; v.pre_valid = pv;
    v.count = c; v.fetch = f; v.pc = p;
    vq.push_back(v);
  endtask

  task automatic chk_state(input string tag, input int unsigned c, input logic [5:0] f,
                           input logic [5:0] p);
    logic [31:0] ei;
    ei = (c != 0) ? imem[p] : 32'd0;
    chk({tag, "_count"}, 64'(bus.Count), 64'(c));
    chk({tag, "_fetch"}, 64'(bus.FetchAddr), 64'(f));
    chk({tag, "_pc"}, 64'(bus.InstrPC), 64'(p));
    chk({tag, "_valid"}, 64'(bus.InstrValid), 64'(c != 0));
    chk({tag, "_instr"}, 64'(bus.Instr), 64'(ei));
  endtask

  initial begin
    int unsigned pops;
    exp_t e;
    for (int i = 0; i < 64; i++) imem[i] = $urandom ^ (32'(i) << 24);
    bus.Redirect = 1'b0;
    bus.RedirectAddr = 6'd0;
    bus.InstrReady = 1'b0;

    // Reset state
    #23;
    chk_state("reset", 0, 6'd0, 6'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("first_edge", 2, 6'd2, 6'd0);

    // redirect raddr ready | pre_valid | post count fetch pc
    add(0, 0,  0, 1, 4, 4,  0);
    add(0, 0,  0, 1, 6, 6,  0);
    add(0, 0,  0, 1, 8, 8,  0);
    add(0, 0,  0, 1, 8, 8,  0);   // full: fetch holds
    add(0, 0,  1, 1, 7, 8,  1);
    add(0, 0,  1, 1, 6, 8,  2);   // Count 7: no push
    add(0, 0,  0, 1, 8, 10, 2);
    add(1, 62, 1, 0, 0, 62, 0);   // redirect while full, no pop
    add(0, 0,  0, 0, 2, 0,  62);
    add(0, 0,  0, 1, 4, 2,  62);
    add(0, 0,  1, 1, 5, 4,  63);
    add(0, 0,  1, 1, 6, 6,  0);
    add(1, 63, 0, 0, 0, 63, 0);
    add(0, 0,  0, 0, 1, 0,  63);  // single entry at 63
    add(0, 0,  1, 1, 2, 2,  0);
    add(0, 0,  1, 1, 3, 4,  1);
    add(1, 10, 1, 0, 0, 10, 0);
    add(1, 20, 1, 0, 0, 20, 0);   // held redirect reloads
    add(0, 0,  0, 0, 2, 22, 20);
    add(0, 0,  0, 1, 4, 24, 20);
    add(0, 0,  1, 1, 5, 26, 21);

    for (int i = 0; i < vq.size(); i++) begin
      bus.Redirect = vq[i].redirect;
      bus.RedirectAddr = vq[i].raddr;
      bus.InstrReady = vq[i].ready;
      #1;
      chk($sformatf("v%0d_pre_valid", i), 64'(bus.InstrValid), 64'(vq[i].pre_valid));
      @(posedge clk); #1;
      bus.Redirect = 1'b0;
      bus.InstrReady = 1'b0;
      #1;
      chk_state($sformatf("v%0d", i), vq[i].count, vq[i].fetch, vq[i].pc);
    end

    // Async reset mid-cycle with Count=5
    #1;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 6'd0, 6'd0);
    bus.InstrReady = 1'b1;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.instr = imem[i];
      e.pc = 6'(i);
      sb.push_back(e);
    end
    #1;
    rst_n = 1'b1;

    // Streaming with InstrReady=1
    pops = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k <= 6) chk($sformatf("stream_count%0d", k), 64'(bus.Count), 64'(k + 1));
      else chk($sformatf("stream_count_range%0d", k),
               64'(bus.Count == 6 || bus.Count == 7), 64'd1);
      if (bus.InstrValid) begin
        if (sb.size() == 0) begin
          chk("stream_sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("stream_entry%0d", k), {26'd0, bus.Instr, bus.InstrPC},
              {26'd0, e.instr, e.pc});
          pops++;
        end
      end
    end
    chk("stream_pops", 64'(pops), 64'd40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
